i2c_master_ctrl: RTL and testbench

//  Single-master I2C controller that sequences register-write and register-read

---
 rtl/i2c_master_ctrl_if.sv | 26 ++
 rtl/i2c_master_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_if.sv
// Command handshake and I2C pin bundle shared by i2c_master_ctrl and its command source.
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ack_err;
    logic       scl;
    logic       sda_out;
    logic       sda_oe;
    logic       sda_in;

    modport master (
        input  start, rw, dev_addr, reg_addr, wdata, sda_in,
        output busy, done, rdata, ack_err, scl, sda_out, sda_oe
    );

    modport slave (
        output start, rw, dev_addr, reg_addr, wdata, sda_in,
        input  busy, done, rdata, ack_err, scl, sda_out, sda_oe
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C register write/read sequencer with four-quarter bit timing.
// Optional I2C_ACK_CHECK_EN: a NACK in any slave ACK slot aborts to STOP and sets ack_err.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    i2c_master_ctrl_if.master bus
);
    localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StStart  = 4'd1;
    localparam logic [3:0] StAddr   = 4'd2;
    localparam logic [3:0] StAck1   = 4'd3;
    localparam logic [3:0] StReg    = 4'd4;
    localparam logic [3:0] StAck2   = 4'd5;
    localparam logic [3:0] StWdata  = 4'd6;
    localparam logic [3:0] StAck3   = 4'd7;
    localparam logic [3:0] StRstart = 4'd8;
    localparam logic [3:0] StRaddr  = 4'd9;
    localparam logic [3:0] StAck4   = 4'd10;
    localparam logic [3:0] StRdata  = 4'd11;
    localparam logic [3:0] StMnack  = 4'd12;
    localparam logic [3:0] StStop   = 4'd13;

    logic [3:0]      state_q, state_d, nxt;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic            rw_q, rw_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d, wdata_q, wdata_d;
    logic [7:0]      rx_q, rx_d, rdata_q, rdata_d;
    logic            ack_err_q, ack_err_d, busy_q, busy_d, done_q, done_d;
    logic            is_byte, bit_end, sample;
    logic [7:0]      tx_byte;
    logic            scl_c, sda_out_c, sda_oe_c;

    assign bit_end = (qtr_q == 2'd3) && (div_q == DivLast);
    assign sample  = (qtr_q == 2'd2) && (div_q == '0);

    always_comb begin
        nxt     = StIdle;
        is_byte = 1'b0;
        case (state_q)
            StStart:  nxt = StAddr;
            StAddr:   begin nxt = StAck1;  is_byte = 1'b1; end
            StAck1:   nxt = ack_err_q ? StStop : StReg;
            StReg:    begin nxt = StAck2;  is_byte = 1'b1; end
            StAck2:   nxt = ack_err_q ? StStop : (rw_q ? StRstart : StWdata);
            StWdata:  begin nxt = StAck3;  is_byte = 1'b1; end
            StAck3:   nxt = StStop;
            StRstart: nxt = StRaddr;
            StRaddr:  begin nxt = StAck4;  is_byte = 1'b1; end
            StAck4:   nxt = ack_err_q ? StStop : StRdata;
            StRdata:  begin nxt = StMnack; is_byte = 1'b1; end
            StMnack:  nxt = StStop;
            default:  nxt = StIdle;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (state_q == StIdle) begin
            div_d = '0;
            qtr_d = 2'd0;
            bit_d = 3'd0;
            if (bus.start) begin
                rw_d      = bus.rw;
                dev_d     = bus.dev_addr;
                reg_d     = bus.reg_addr;
                wdata_d   = bus.wdata;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
                state_d   = StStart;
            end
        end else begin
            if (div_q == DivLast) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + DivW'(1);
            end
            if (sample) begin
                if (state_q == StRdata) rx_d = {rx_q[6:0], bus.sda_in};
`ifdef I2C_ACK_CHECK_EN
                if ((state_q == StAck1 || state_q == StAck2 || state_q == StAck3 ||
                     state_q == StAck4) && bus.sda_in) ack_err_d = 1'b1;
`endif
            end
            if (bit_end) begin
                if (is_byte) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = nxt;
                end else begin
                    state_d = nxt;
                end
                if (state_q == StStop) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    // An aborted read leaves the previous rdata in place.
                    if (rw_q && !ack_err_q) rdata_d = rx_q;
                end
            end
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            StAddr:  tx_byte = {dev_q, 1'b0};
            StReg:   tx_byte = reg_q;
            StWdata: tx_byte = wdata_q;
            StRaddr: tx_byte = {dev_q, 1'b1};
            default: tx_byte = 8'h00;
        endcase
        scl_c     = (qtr_q != 2'd0);
        sda_out_c = 1'b1;
        sda_oe_c  = 1'b1;
        // START/RSTART pull SDA low in the second half; STOP releases it there.
        case (state_q)
            StIdle:   begin scl_c = 1'b1; sda_oe_c = 1'b0; end
            StStart:  begin scl_c = 1'b1; sda_out_c = ~qtr_q[1]; end
            StRstart: sda_out_c = ~qtr_q[1];
            StStop:   sda_out_c = qtr_q[1];
            StAddr, StReg, StWdata, StRaddr: sda_out_c = tx_byte[3'd7 - bit_q];
            StMnack:  sda_out_c = 1'b1;
            default:  sda_oe_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            rdata_q   <= 8'h00;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.ack_err = ack_err_q;
    assign bus.scl     = scl_c;
    assign bus.sda_out = sda_out_c;
    assign bus.sda_oe  = sda_oe_c;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: table of commands plus busy-restart and mid-frame reset cases.
module tb_i2c_master_ctrl;
    localparam int unsigned CLK_DIV = 2;
    localparam int BitClk = 4 * CLK_DIV;
    localparam int WrLat  = 29 * BitClk + 1;
    localparam int RdLat  = 39 * BitClk + 1;
    localparam int NakLat = 11 * BitClk + 1;

    typedef logic [0:10][9:0] frame_t;
    // Codes: 0x100 START, 0x101 STOP, 0x200|b ACK slot, 0x0xx byte, 0x3FF unused.
    localparam frame_t FrWr = {10'h100, 10'h0A0, 10'h200, 10'h025, 10'h200, 10'h0A5,
                               10'h200, 10'h101, 10'h3FF, 10'h3FF, 10'h3FF};
    localparam frame_t FrRd = {10'h100, 10'h0A0, 10'h200, 10'h025, 10'h200, 10'h100,
                               10'h0A1, 10'h200, 10'h010, 10'h201, 10'h101};
    localparam frame_t FrNak = {10'h100, 10'h0A0, 10'h201, 10'h101, 10'h3FF, 10'h3FF,
                                10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    localparam frame_t FrNoSlv = {10'h100, 10'h0A0, 10'h201, 10'h025, 10'h201, 10'h0A5,
                                  10'h201, 10'h101, 10'h3FF, 10'h3FF, 10'h3FF};

    typedef struct {
        string      name;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] ra;
        logic [7:0] wd;
        logic       slv;
        int         lat;
        logic [7:0] rdata;
        logic       ackerr;
        int         nfr;
        frame_t     fr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Open-drain line with a register-file slave that can pull SDA low.
    logic       slave_en  = 1'b1;
    logic       slave_low = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1, rd_mode = 1'b0;
    int         bitn = 0;
    logic [7:0] sh = 8'h00, ptr = 8'h00, rd_byte;
    logic [9:0] cap[$];

    assign bus.sda_in = (bus.sda_oe ? bus.sda_out : 1'b1) & ~slave_low;
    assign rd_byte    = (ptr == 8'h25) ? 8'h10 : 8'hEE;

    always @(negedge clk) begin
        scl_p <= bus.scl;
        sda_p <= bus.sda_in;
        if (rst) begin
            slave_low <= 1'b0;
        end else if (scl_p && bus.scl && sda_p && !bus.sda_in) begin
            bitn    <= 0;
            rd_mode <= 1'b0;
            cap.push_back(10'h100);
        end else if (scl_p && bus.scl && !sda_p && bus.sda_in) begin
            cap.push_back(10'h101);
        end else if (!scl_p && bus.scl) begin
            sh   <= {sh[6:0], bus.sda_in};
            bitn <= bitn + 1;
            if (bitn % 9 == 8) begin
                cap.push_back({2'b10, 7'd0, bus.sda_in});
                if (rd_mode && bitn / 9 >= 1) rd_mode <= 1'b0;
            end else if (bitn % 9 == 7) begin
                cap.push_back({2'b00, sh[6:0], bus.sda_in});
                if (bitn == 7) rd_mode <= bus.sda_in;
                if (bitn == 16 && !rd_mode) ptr <= {sh[6:0], bus.sda_in};
            end
        end else if (scl_p && !bus.scl) begin
            if (bitn % 9 == 8) slave_low <= slave_en && (bitn / 9 == 0 || !rd_mode);
            else if (rd_mode && bitn / 9 >= 1) slave_low <= slave_en && !rd_byte[7 - bitn % 9];
            else slave_low <= 1'b0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input int base, input frame_t fr, input int n);
        chk({nm, " frame_len"}, cap.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < cap.size()) chk($sformatf("%s frame[%0d]", nm, i), cap[base + i], fr[i]);
    endtask

    task automatic do_cmd(input string nm, input logic rw, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd, input bit glitch,
                          output int lat);
        int cnt;
        @(negedge clk);
        bus.rw = rw; bus.dev_addr = dev; bus.reg_addr = ra; bus.wdata = wd; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 1;
        chk({nm, " busy_after_accept"}, bus.busy, 1);
        chk({nm, " ack_err_cleared"}, bus.ack_err, 0);
        while (!bus.done && cnt < 1000) begin
            if (glitch && cnt == 20) begin
                bus.start = 1'b1; bus.rw = ~rw; bus.dev_addr = 7'h13;
                bus.reg_addr = 8'h77; bus.wdata = 8'h3C;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        bus.start = 1'b0;
        chk({nm, " busy_at_done"}, bus.busy, 0);
        lat = bus.done ? cnt : -1;
    endtask

    vec_t vecs[3];

    initial begin
        int base, lat, hits;
        vecs[0] = '{"write", 1'b0, 7'h50, 8'h25, 8'hA5, 1'b1, WrLat, 8'h00, 1'b0, 8, FrWr};
        vecs[1] = '{"read", 1'b1, 7'h50, 8'h25, 8'h00, 1'b1, RdLat, 8'h10, 1'b0, 11, FrRd};
`ifdef I2C_ACK_CHECK_EN
        vecs[2] = '{"nack_abort", 1'b0, 7'h50, 8'h25, 8'hA5, 1'b0, NakLat, 8'h10, 1'b1, 4, FrNak};
`else
        vecs[2] = '{"no_slave", 1'b0, 7'h50, 8'h25, 8'hA5, 1'b0, WrLat, 8'h10, 1'b0, 8, FrNoSlv};
`endif
        bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = 7'h00;
        bus.reg_addr = 8'h00; bus.wdata = 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset scl", bus.scl, 1);
        chk("reset sda_out", bus.sda_out, 1);
        chk("reset sda_oe", bus.sda_oe, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset rdata", bus.rdata, 0);
        chk("reset ack_err", bus.ack_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            slave_en = vecs[i].slv;
            base = cap.size();
            do_cmd(vecs[i].name, vecs[i].rw, vecs[i].dev, vecs[i].ra, vecs[i].wd, 1'b0, lat);
            chk({vecs[i].name, " latency"}, lat, vecs[i].lat);
            chk({vecs[i].name, " rdata"}, bus.rdata, vecs[i].rdata);
            chk({vecs[i].name, " ack_err"}, bus.ack_err, vecs[i].ackerr);
            chk_frame(vecs[i].name, base, vecs[i].fr, vecs[i].nfr);
        end
        repeat (5) @(negedge clk);
        chk("ack_err sticky", bus.ack_err, vecs[2].ackerr);

        // A second start while busy must neither alter the frame nor queue a command.
        slave_en = 1'b1;
        base = cap.size();
        do_cmd("busy_restart", 1'b0, 7'h50, 8'h25, 8'hA5, 1'b1, lat);
        chk("busy_restart latency", lat, WrLat);
        chk("busy_restart ack_err", bus.ack_err, 0);
        chk_frame("busy_restart", base, FrWr, 8);
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy) hits++;
        end
        chk("busy_restart no_queue", hits, 0);

        // Reset in the middle of the register byte.
        @(negedge clk);
        bus.rw = 1'b0; bus.dev_addr = 7'h50; bus.reg_addr = 8'h25; bus.wdata = 8'hA5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_reset busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_reset scl", bus.scl, 1);
        chk("mid_reset sda_oe", bus.sda_oe, 0);
        chk("mid_reset busy", bus.busy, 0);
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) hits++;
        end
        chk("mid_reset no_done", hits, 0);
        chk("mid_reset rdata", bus.rdata, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        base = cap.size();
        do_cmd("after_reset", 1'b0, 7'h50, 8'h25, 8'hA5, 1'b0, lat);
        chk("after_reset latency", lat, WrLat);
        chk("after_reset ack_err", bus.ack_err, 0);
        chk_frame("after_reset", base, FrWr, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
